// File: rtl/digit_serial_adder3_if.sv
// rtl/digit_serial_adder3_if.sv - handshake and operand/result bundle for digit_serial_adder3 (optional ovf under DIGIT_SERIAL_ADDER3_OVF_EN)
interface digit_serial_adder3_if #(
   parameter int WIDTH = 12
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             cin;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] sum;
   logic             cout;
   logic             busy;
`ifdef DIGIT_SERIAL_ADDER3_OVF_EN
   logic             ovf;

   modport master (
      output in_valid, a, b, cin, out_ready,
      input  in_ready, out_valid, sum, cout, busy, ovf
   );

   modport slave (
      input  in_valid, a, b, cin, out_ready,
      output in_ready, out_valid, sum, cout, busy, ovf
   );
`else
   modport master (
      output in_valid, a, b, cin, out_ready,
      input  in_ready, out_valid, sum, cout, busy
   );

   modport slave (
      input  in_valid, a, b, cin, out_ready,
      output in_ready, out_valid, sum, cout, busy
   );
`endif
endinterface

// File: rtl/digit_serial_adder3.sv
// rtl/digit_serial_adder3.sv - 3-bit-per-cycle serial adder with valid/ready handshake (optional signed overflow under DIGIT_SERIAL_ADDER3_OVF_EN)
module digit_serial_adder3 #(
   parameter int WIDTH = 12
) (
   input logic                 clk,
   input logic                 rst,
   digit_serial_adder3_if.slave bus
);
   localparam int NDIG = WIDTH / 3;
   localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;

   if (((WIDTH % 3) != 0) || (WIDTH < 3)) begin : g_bad_width
      $error("digit_serial_adder3: WIDTH must be a multiple of 3 and at least 3");
   end

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           state;
   state_t           state_nxt;
   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] b_q;
   logic [WIDTH-1:0] sum_q;
   logic             carry_q;
   logic             cout_q;
   logic [CW-1:0]    cnt_q;
   logic [3:0]       digit;
   logic             last_digit;
   logic             ready;
   logic             valid;
   logic             running;

   // Extended copies let the right shift by one digit work even when WIDTH == 3.
   logic [WIDTH+2:0] a_ext;
   logic [WIDTH+2:0] b_ext;
   logic [WIDTH+2:0] sum_ext;

   assign digit      = {1'b0, a_q[2:0]} + {1'b0, b_q[2:0]} + {3'b000, carry_q};
   assign last_digit = (cnt_q == CW'(NDIG - 1));
   assign a_ext      = {3'b000, a_q};
   assign b_ext      = {3'b000, b_q};
   assign sum_ext    = {digit[2:0], sum_q};

`ifdef DIGIT_SERIAL_ADDER3_OVF_EN
   logic       ovf_q;
   logic [2:0] low2;

   // Carry into the top bit of the current digit; only meaningful on the final digit.
   assign low2    = {1'b0, a_q[1:0]} + {1'b0, b_q[1:0]} + {2'b00, carry_q};
   assign bus.ovf = ovf_q;
`endif

   assign bus.in_ready  = ready;
   assign bus.out_valid = valid;
   assign bus.busy      = running;
   assign bus.sum       = sum_q;
   assign bus.cout      = cout_q;

   // State register; reset abandons any operation in flight.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state and handshake outputs; no bypass from DONE straight to a new accept.
   always_comb begin
      state_nxt = state;
      ready     = 1'b0;
      valid     = 1'b0;
      running   = 1'b0;
      case (state)
         IDLE: begin
            ready = 1'b1;
            if (bus.in_valid) begin
               state_nxt = RUN;
            end
         end
         RUN: begin
            running = 1'b1;
            if (last_digit) begin
               state_nxt = DONE;
            end
         end
         DONE: begin
            valid = 1'b1;
            if (bus.out_ready) begin
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Operand capture, one slice step per RUN cycle, and final carry capture.
   always_ff @(posedge clk) begin
      if (rst) begin
         a_q     <= '0;
         b_q     <= '0;
         sum_q   <= '0;
         carry_q <= 1'b0;
         cout_q  <= 1'b0;
         cnt_q   <= '0;
`ifdef DIGIT_SERIAL_ADDER3_OVF_EN
         ovf_q   <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (bus.in_valid) begin
                  a_q     <= bus.a;
                  b_q     <= bus.b;
                  carry_q <= bus.cin;
                  sum_q   <= '0;
                  cnt_q   <= '0;
               end
            end
            RUN: begin
               a_q     <= a_ext[WIDTH+2:3];
               b_q     <= b_ext[WIDTH+2:3];
               sum_q   <= sum_ext[WIDTH+2:3];
               carry_q <= digit[3];
               cnt_q   <= cnt_q + CW'(1);
               if (last_digit) begin
                  cout_q <= digit[3];
`ifdef DIGIT_SERIAL_ADDER3_OVF_EN
                  ovf_q  <= low2[2] ^ digit[3];
`endif
               end
            end
            default: begin
            end
         endcase
      end
   end
endmodule

// File: doc/digit_serial_adder3.md
Name: digit_serial_adder3

Overview:
- Sequential operand sequencer that adds two WIDTH-bit operands 3 bits per cycle, using one 3-bit-plus-carry adder slice per digit.
- The slice computes a[2:0] + b[2:0] + cin and returns a 4-bit result: sum[2:0] plus carry-out.
- The block sits upstream of the slice: it latches the operands, presents one digit pair and the running carry each cycle, and shifts the slice results into a sum register.
- It has a valid/ready handshake on both the input and output sides.

Parameters:
- WIDTH, 12, operand and sum width in bits. Must be a multiple of 3 and at least 3; elaboration fails otherwise.
- Local parameter NDIG = WIDTH/3, the number of digits and the number of RUN cycles.

Ports:
- clk  input  1  single clock, rising-edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operand pair is presented.
- in_ready  output  1  block accepts operands this cycle.
- a  input  WIDTH  operand A, unsigned.
- b  input  WIDTH  operand B, unsigned.
- cin  input  1  initial carry-in.
- out_valid  output  1  result is available.
- out_ready  input  1  consumer takes the result.
- sum  output  WIDTH  (a + b + cin) mod 2^WIDTH.
- cout  output  1  final carry-out.
- busy  output  1  high while in RUN.

Behaviour:
- Reset (rst=1 at a clock edge):
  - state goes to IDLE; digit counter, carry, operand and sum registers go to 0.
  - Outputs: in_ready=1 (combinational from IDLE), out_valid=0, sum=0, cout=0, busy=0.
  - Reset mid-operation abandons the operation; no partial result is ever presented.
- State machine: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready: latch a, b and cin into the carry register; clear the counter and sum register; go to RUN.
- RUN (NDIG cycles):
  - in_ready=0, busy=1.
  - Each cycle, the slice adds the low digits of the operand shift registers plus the carry register.
  - Slice sum[2:0] enters the sum register at the top, which shifts right by 3; the operand registers shift right by 3; carry ← slice carry-out; counter increments.
  - On the cycle the counter equals NDIG-1: go to DONE.
- DONE:
  - out_valid=1; sum and cout are stable and held until the handshake.
  - On out_valid&out_ready: go to IDLE. out_valid drops the next cycle; sum and cout hold their last value.
- No bypass: in_ready=0 in DONE, so a new operand cannot be accepted in the same cycle a result is taken.
- Latency: accept at cycle t gives out_valid at cycle t+NDIG+1 (registered); out_ready is honoured from that cycle.
- Back-to-back throughput: one operation per NDIG+2 cycles with out_ready tied high.
- Arithmetic:
  - Slice carry-out is {a_d, b_d, c} summed, bit 3.
  - Final cout equals bit WIDTH of the full (WIDTH+1)-bit sum.
- Boundary conditions:
  - Wrap-around: all-ones + 1 gives sum=0, cout=1.
  - Counter width is clog2(NDIG), with a minimum of 1. For NDIG=1, RUN lasts exactly one cycle.
  - in_valid while not in IDLE is ignored; the operand is not consumed.
  - out_ready while not in DONE has no effect.
  - rst asserted together with in_valid: reset wins; nothing is accepted.

Optional Feature:
- Macro: DIGIT_SERIAL_ADDER3_OVF_EN.
- Defined:
  - Adds output port ovf (1 bit): the signed two's-complement overflow of a + b + cin.
  - Computed as the carry into the MSB XOR the carry out of the MSB, captured from the final RUN digit.
  - Valid with out_valid, held with sum; reset value 0.
- Undefined: the port and its logic are absent. All other behaviour is identical.

Test Plan:
- Reset then single add, WIDTH=12: a=0x123, b=0x456, cin=0, out_ready=1 → out_valid at accept+5 cycles, sum=0x579, cout=0, busy high exactly 4 cycles.
- Wrap-around: a=0xFFF, b=0x000, cin=1 → sum=0x000, cout=1. With OVF_EN: ovf=0.
- Signed overflow (OVF_EN): a=0x7FF, b=0x001, cin=0 → sum=0x800, cout=0, ovf=1.
- Backpressure and ignored input:
  - Setup: hold out_ready=0 for 10 cycles after out_valid rises, while driving in_valid=1 with a=0x001, b=0x001.
  - Required: out_valid stays high; sum and cout stay stable; in_ready stays 0; the second operand is not accepted until the cycle after out_ready=1.
  - Then the second result is 0x002.
- Reset mid-RUN: accept a=0xABC, b=0x111, assert rst on the 2nd RUN cycle → next cycle state IDLE, in_ready=1, out_valid=0, sum=0; a fresh add of 0x001+0x002 returns 0x003.
- Random regression: 1000 random a, b, cin with random out_ready stalls against a reference add → sum/cout (and ovf) always match; accepts equal results, none lost or duplicated.
